// File: rtl/qram_access_scheduler.sv
// Round-robin access sequencer for a bank of QRAM cells: requests from A and B
// become SETUP / STROBE / HOLD / ACK sequences, with periodic read-then-write-back refresh.
module qram_access_scheduler #(
    parameter int ADDR_W           = 4,
    parameter int SETTLE           = 2,
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic              DDRClockP,
    input  logic              nReset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WriteA,
    input  logic              WriteB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic              DataA,
    input  logic              DataB,
    output logic              AckA,
    output logic              AckB,
    output logic              RdData,
    output logic [ADDR_W-1:0] CellAddr,
    output logic              CellDataOut,
    output logic              WriteEdge,
    output logic              ReadEdge,
    input  logic              CellDataIn,
    output logic              Busy,
    output logic              RefreshLate,
    output logic [2:0]        DbgState
);

    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(SETTLE - 1);
    localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t              state_q;
    logic                is_ref_q;
    logic                ref_wr_q;
    logic                op_wr_q;
    logic                sel_b_q;
    logic                last_b_q;
    logic [HW-1:0]       hold_q;
    logic [ADDR_W-1:0]   ref_addr_q;
    logic [ADDR_W-1:0]   cell_addr_q;
    logic                cell_data_q;
    logic                wr_edge_q;
    logic                rd_edge_q;
    logic                ack_a_q;
    logic                ack_b_q;
    logic                rd_data_q;

    logic [RW-1:0]       ref_cnt_q, ref_cnt_d;
    logic                ref_due_q, ref_due_d;
    logic                ref_late_q, ref_late_d;

    logic                hold_last;
    logic                ref_done;
    logic                ref_expire;
    logic                grant_b;

    assign hold_last  = (hold_q == HOLD_LAST);
    assign ref_done   = (state_q == HOLD) && is_ref_q && ref_wr_q && hold_last;
    assign ref_expire = (ref_cnt_q == '0);

    // B wins only when A is idle or A was the previous grantee.
    assign grant_b = ReqB && (!ReqA || !last_b_q);

    always_comb begin
        ref_cnt_d  = ref_expire ? REF_RELOAD : (ref_cnt_q - RW'(1));
        ref_due_d  = ref_due_q;
        ref_late_d = ref_late_q | (ref_expire & ref_due_q);
        if (ref_done) begin
            ref_due_d = 1'b0;
        end
        // A fresh expiry on the completion edge keeps refresh pending.
        if (ref_expire) begin
            ref_due_d = 1'b1;
        end
    end

    always_ff @(posedge DDRClockP or negedge nReset) begin
        if (!nReset) begin
            ref_cnt_q  <= REF_RELOAD;
            ref_due_q  <= 1'b0;
            ref_late_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_due_q  <= ref_due_d;
            ref_late_q <= ref_late_d;
        end
    end

    always_ff @(posedge DDRClockP or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            is_ref_q    <= 1'b0;
            ref_wr_q    <= 1'b0;
            op_wr_q     <= 1'b0;
            sel_b_q     <= 1'b0;
            last_b_q    <= 1'b1;
            hold_q      <= '0;
            ref_addr_q  <= '0;
            cell_addr_q <= '0;
            cell_data_q <= 1'b0;
            wr_edge_q   <= 1'b0;
            rd_edge_q   <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            rd_data_q   <= 1'b0;
        end else begin
            wr_edge_q <= 1'b0;
            rd_edge_q <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ref_due_q) begin
                        is_ref_q    <= 1'b1;
                        ref_wr_q    <= 1'b0;
                        cell_addr_q <= ref_addr_q;
                        cell_data_q <= 1'b0;
                        state_q     <= SETUP;
                    end else if (ReqA || ReqB) begin
                        is_ref_q    <= 1'b0;
                        sel_b_q     <= grant_b;
                        last_b_q    <= grant_b;
                        op_wr_q     <= grant_b ? WriteB : WriteA;
                        cell_addr_q <= grant_b ? AddrB : AddrA;
                        cell_data_q <= grant_b ? DataB : DataA;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    wr_edge_q <= is_ref_q ? ref_wr_q : op_wr_q;
                    rd_edge_q <= is_ref_q ? !ref_wr_q : !op_wr_q;
                    state_q   <= STROBE;
                end
                STROBE: begin
                    hold_q  <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!hold_last) begin
                        hold_q <= hold_q + HW'(1);
                    end else if (is_ref_q && !ref_wr_q) begin
                        // The sampled qbit becomes the write-back value.
                        cell_data_q <= CellDataIn;
                        ref_wr_q    <= 1'b1;
                        state_q     <= SETUP;
                    end else if (is_ref_q) begin
                        is_ref_q   <= 1'b0;
                        ref_wr_q   <= 1'b0;
                        ref_addr_q <= ref_addr_q + ADDR_W'(1);
                        state_q    <= IDLE;
                    end else begin
                        if (!op_wr_q) begin
                            rd_data_q <= CellDataIn;
                        end
                        ack_a_q <= !sel_b_q;
                        ack_b_q <= sel_b_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign AckA        = ack_a_q;
    assign AckB        = ack_b_q;
    assign RdData      = rd_data_q;
    assign CellAddr    = cell_addr_q;
    assign CellDataOut = cell_data_q;
    assign WriteEdge   = wr_edge_q;
    assign ReadEdge    = rd_edge_q;
    assign Busy        = (state_q != IDLE);
    assign RefreshLate = ref_late_q;
    assign DbgState    = state_q;

    a_one_strobe: assert property (@(posedge DDRClockP) disable iff (!nReset)
        !(WriteEdge && ReadEdge));
    a_one_ack: assert property (@(posedge DDRClockP) disable iff (!nReset)
        !(AckA && AckB));

endmodule

// File: tb/tb_qram_access_scheduler.sv
// Directed bench for qram_access_scheduler: a default-parameter instance plus a
// short-interval, long-settle instance used to provoke a late refresh.
module tb_qram_access_scheduler;

    logic       clk;
    logic       n_reset;
    logic       req_a, req_b, write_a, write_b, data_a, data_b;
    logic [3:0] addr_a, addr_b;
    logic       ack_a, ack_b, rd_data, cell_data_out, write_edge, read_edge, busy, refresh_late;
    logic [3:0] cell_addr;
    logic [2:0] dbg_state;
    logic       cell_data_in;

    logic       l_req_a, l_req_b, l_write_a, l_write_b, l_data_a, l_data_b, l_cell_data_in;
    logic [3:0] l_addr_a, l_addr_b;
    logic       l_ack_a, l_ack_b, l_rd_data, l_cell_data_out, l_write_edge, l_read_edge, l_busy, l_refresh_late;
    logic [3:0] l_cell_addr;
    logic [2:0] l_dbg_state;

    logic [15:0] mem_q;
    logic        mem_clr;

    int tests_run;
    int fails;

    qram_access_scheduler #(.ADDR_W(4), .SETTLE(2), .REFRESH_INTERVAL(64)) u_dut (
        .DDRClockP(clk), .nReset(n_reset),
        .ReqA(req_a), .ReqB(req_b), .WriteA(write_a), .WriteB(write_b),
        .AddrA(addr_a), .AddrB(addr_b), .DataA(data_a), .DataB(data_b),
        .AckA(ack_a), .AckB(ack_b), .RdData(rd_data),
        .CellAddr(cell_addr), .CellDataOut(cell_data_out),
        .WriteEdge(write_edge), .ReadEdge(read_edge), .CellDataIn(cell_data_in),
        .Busy(busy), .RefreshLate(refresh_late), .DbgState(dbg_state)
    );

    qram_access_scheduler #(.ADDR_W(4), .SETTLE(4), .REFRESH_INTERVAL(8)) u_late (
        .DDRClockP(clk), .nReset(n_reset),
        .ReqA(l_req_a), .ReqB(l_req_b), .WriteA(l_write_a), .WriteB(l_write_b),
        .AddrA(l_addr_a), .AddrB(l_addr_b), .DataA(l_data_a), .DataB(l_data_b),
        .AckA(l_ack_a), .AckB(l_ack_b), .RdData(l_rd_data),
        .CellAddr(l_cell_addr), .CellDataOut(l_cell_data_out),
        .WriteEdge(l_write_edge), .ReadEdge(l_read_edge), .CellDataIn(l_cell_data_in),
        .Busy(l_busy), .RefreshLate(l_refresh_late), .DbgState(l_dbg_state)
    );

    // Cell array model: stores on the edge that ends a WriteEdge cycle.
    always @(posedge clk) begin
        if (mem_clr) mem_q <= '0;
        else if (write_edge) mem_q[cell_addr] <= cell_data_out;
    end
    assign cell_data_in = mem_q[cell_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0; mem_clr = 1'b1;
        req_a = 0; req_b = 0; write_a = 0; write_b = 0; data_a = 0; data_b = 0; addr_a = '0; addr_b = '0;
        l_req_a = 0; l_req_b = 0; l_write_a = 0; l_write_b = 0; l_data_a = 0; l_data_b = 0;
        l_addr_a = '0; l_addr_b = '0; l_cell_data_in = 0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0; n_reset = 1'b1;
    endtask

    // Drives one request and records what the DUT did; callers compare.
    task automatic run_op(input bit use_b, input bit wr, input logic [3:0] addr, input bit data,
                          output int strobe_c, output int ack_c, output int ack_w,
                          output logic [1:0] kind, output logic [3:0] s_addr, output logic s_data,
                          output logic rd_val, output bit cross_ack);
        strobe_c = -1; ack_c = -1; ack_w = 0; kind = 2'b00; s_addr = '0; s_data = 1'b0;
        rd_val = 1'b0; cross_ack = 1'b0;
        if (use_b) begin req_b = 1; write_b = wr; addr_b = addr; data_b = data; end
        else begin req_a = 1; write_a = wr; addr_a = addr; data_a = data; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((write_edge || read_edge) && strobe_c < 0) begin
                strobe_c = c; kind = {write_edge, read_edge}; s_addr = cell_addr; s_data = cell_data_out;
            end
            if (use_b ? ack_b : ack_a) begin
                ack_w++;
                if (ack_c < 0) begin ack_c = c; rd_val = rd_data; req_a = 0; req_b = 0; end
            end
            if (use_b ? ack_a : ack_b) cross_ack = 1'b1;
            if (ack_c > 0 && c >= ack_c + 2) break;
        end
        req_a = 0; req_b = 0;
    endtask

    task automatic test_reset();
        logic [14:0] vec;
        do_reset();
        vec = {ack_a, ack_b, rd_data, cell_addr, cell_data_out, write_edge, read_edge, busy, refresh_late, dbg_state};
        tests_run++; if (vec !== 15'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", vec); end
        vec = {l_ack_a, l_ack_b, l_rd_data, l_cell_addr, l_cell_data_out, l_write_edge, l_read_edge, l_busy, l_refresh_late, l_dbg_state};
        tests_run++; if (vec !== 15'd0) begin fails++; $display("FAIL reset_outputs_late_inst: got %h expected 0", vec); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_read();
        int sc, ac, aw; logic [1:0] kd; logic [3:0] sa; logic sd, rv; bit xa;
        run_op(0, 1, 4'd3, 1, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (sc !== 2) begin fails++; $display("FAIL wr_strobe_cycle: got %0d expected 2", sc); end
        tests_run++; if (kd !== 2'b10) begin fails++; $display("FAIL wr_strobe_kind: got %b expected 10", kd); end
        tests_run++; if (sa !== 4'd3) begin fails++; $display("FAIL wr_cell_addr: got %0d expected 3", sa); end
        tests_run++; if (sd !== 1'b1) begin fails++; $display("FAIL wr_cell_data: got %b expected 1", sd); end
        tests_run++; if (ac !== 5) begin fails++; $display("FAIL wr_ack_cycle: got %0d expected 5", ac); end
        tests_run++; if (aw !== 1) begin fails++; $display("FAIL wr_ack_width: got %0d expected 1", aw); end
        tests_run++; if (xa !== 1'b0) begin fails++; $display("FAIL wr_wrong_ack: got %b expected 0", xa); end
        run_op(0, 0, 4'd3, 0, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (kd !== 2'b01) begin fails++; $display("FAIL rd_strobe_kind: got %b expected 01", kd); end
        tests_run++; if (ac !== 5) begin fails++; $display("FAIL rd_ack_cycle: got %0d expected 5", ac); end
        tests_run++; if (rv !== 1'b1) begin fails++; $display("FAIL rd_data_a3: got %b expected 1", rv); end
        run_op(1, 1, 4'd9, 0, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (sa !== 4'd9) begin fails++; $display("FAIL b_wr_cell_addr: got %0d expected 9", sa); end
        tests_run++; if (xa !== 1'b0) begin fails++; $display("FAIL b_wr_wrong_ack: got %b expected 0", xa); end
        tests_run++; if (rd_data !== 1'b1) begin fails++; $display("FAIL rd_data_held: got %b expected 1", rd_data); end
        run_op(1, 0, 4'd9, 0, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (rv !== 1'b0) begin fails++; $display("FAIL rd_data_b9: got %b expected 0", rv); end
        tests_run++; if (ac !== 5) begin fails++; $display("FAIL b_rd_ack_cycle: got %0d expected 5", ac); end
    endtask

    task automatic test_round_robin();
        bit who[3]; int when[3]; int n, both, wide; logic prev_a, prev_b, rdb;
        n = 0; both = 0; wide = 0; prev_a = 0; prev_b = 0; rdb = 1'b0;
        for (int i = 0; i < 3; i++) begin who[i] = 0; when[i] = -1; end
        do_reset();
        req_a = 1; write_a = 1; addr_a = 4'd1; data_a = 1;
        req_b = 1; write_b = 0; addr_b = 4'd1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack_a && ack_b) both++;
            if ((ack_a && prev_a) || (ack_b && prev_b)) wide++;
            prev_a = ack_a; prev_b = ack_b;
            if (ack_a || ack_b) begin
                if (n < 3) begin who[n] = ack_b; when[n] = k; if (ack_b) rdb = rd_data; end
                n++;
                if (n == 3) begin req_a = 0; req_b = 0; end
            end
        end
        tests_run++; if ({who[0], who[1], who[2]} !== 3'b010) begin fails++; $display("FAIL rr_order: got %b%b%b expected 010 (A,B,A)", who[0], who[1], who[2]); end
        tests_run++; if (when[0] !== 5 || when[1] !== 11 || when[2] !== 17) begin fails++; $display("FAIL rr_ack_cycles: got %0d,%0d,%0d expected 5,11,17", when[0], when[1], when[2]); end
        tests_run++; if (both !== 0) begin fails++; $display("FAIL rr_simultaneous_ack: got %0d expected 0", both); end
        tests_run++; if (wide !== 0) begin fails++; $display("FAIL rr_ack_width: got %0d wide acks expected 0", wide); end
        tests_run++; if (n !== 3) begin fails++; $display("FAIL rr_ack_count: got %0d expected 3", n); end
        tests_run++; if (rdb !== 1'b1) begin fails++; $display("FAIL rr_b_read_data: got %b expected 1", rdb); end
    endtask

    task automatic test_refresh();
        int busy_first, busy_cnt, rd1_k, rd2_k, wr1_k, acks;
        logic [3:0] rd1_addr, rd2_addr, wr1_addr; logic wr1_data;
        busy_first = -1; busy_cnt = 0; rd1_k = -1; rd2_k = -1; wr1_k = -1; acks = 0;
        rd1_addr = 'x; rd2_addr = 'x; wr1_addr = 'x; wr1_data = 1'bx;
        do_reset();
        req_a = 1; write_a = 1; addr_a = 4'd0; data_a = 1;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            if (ack_a) req_a = 0;
            if (k >= 60) begin
                if (ack_a || ack_b) acks++;
                if (busy && k <= 100) begin busy_cnt++; if (busy_first < 0) busy_first = k; end
                if (read_edge && k <= 100 && rd1_k < 0) begin rd1_k = k; rd1_addr = cell_addr; end
                if (read_edge && k > 100 && rd2_k < 0) begin rd2_k = k; rd2_addr = cell_addr; end
                if (write_edge && k <= 100 && wr1_k < 0) begin wr1_k = k; wr1_addr = cell_addr; wr1_data = cell_data_out; end
            end
        end
        req_a = 0;
        tests_run++; if (busy_first !== 65) begin fails++; $display("FAIL ref_start_cycle: got %0d expected 65", busy_first); end
        tests_run++; if (busy_cnt !== 8) begin fails++; $display("FAIL ref_busy_cycles: got %0d expected 8", busy_cnt); end
        tests_run++; if (rd1_k !== 66 || rd1_addr !== 4'd0) begin fails++; $display("FAIL ref_read_strobe: got cycle %0d addr %0d expected 66 addr 0", rd1_k, rd1_addr); end
        tests_run++; if (wr1_k !== 70 || wr1_addr !== 4'd0) begin fails++; $display("FAIL ref_write_strobe: got cycle %0d addr %0d expected 70 addr 0", wr1_k, wr1_addr); end
        tests_run++; if (wr1_data !== 1'b1) begin fails++; $display("FAIL ref_writeback_value: got %b expected 1", wr1_data); end
        tests_run++; if (acks !== 0) begin fails++; $display("FAIL ref_no_ack: got %0d expected 0", acks); end
        tests_run++; if (rd2_k !== 130 || rd2_addr !== 4'd1) begin fails++; $display("FAIL ref_second_target: got cycle %0d addr %0d expected 130 addr 1", rd2_k, rd2_addr); end
        tests_run++; if (mem_q[0] !== 1'b1) begin fails++; $display("FAIL ref_cell0_kept: got %b expected 1", mem_q[0]); end
    endtask

    task automatic test_refresh_vs_req();
        int busy_first, rd1_k, b_wr_k, ackb_k, ackb_n, acka_n; logic [3:0] rd1_addr;
        busy_first = -1; rd1_k = -1; b_wr_k = -1; ackb_k = -1; ackb_n = 0; acka_n = 0; rd1_addr = 'x;
        do_reset();
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (busy && busy_first < 0) busy_first = k;
            if (read_edge && rd1_k < 0) begin rd1_k = k; rd1_addr = cell_addr; end
            if (write_edge && cell_addr == 4'd6 && b_wr_k < 0) b_wr_k = k;
            if (ack_a) acka_n++;
            if (ack_b) begin ackb_n++; if (ackb_k < 0) ackb_k = k; req_b = 0; end
            if (k == 64) begin req_b = 1; write_b = 1; addr_b = 4'd6; data_b = 1; end
        end
        req_b = 0;
        tests_run++; if (busy_first !== 65) begin fails++; $display("FAIL rvr_start: got %0d expected 65", busy_first); end
        tests_run++; if (rd1_k !== 66 || rd1_addr !== 4'd0) begin fails++; $display("FAIL rvr_refresh_first: got cycle %0d addr %0d expected 66 addr 0", rd1_k, rd1_addr); end
        tests_run++; if (b_wr_k !== 75) begin fails++; $display("FAIL rvr_b_strobe: got %0d expected 75", b_wr_k); end
        tests_run++; if (ackb_k !== 78 || ackb_n !== 1) begin fails++; $display("FAIL rvr_ack_b: got cycle %0d count %0d expected 78 count 1", ackb_k, ackb_n); end
        tests_run++; if (acka_n !== 0) begin fails++; $display("FAIL rvr_no_ack_a: got %0d expected 0", acka_n); end
    endtask

    task automatic test_refresh_late();
        logic late15, late16; int first, drops, acks; logic [14:0] vec;
        late15 = 1'bx; late16 = 1'bx; first = -1; drops = 0; acks = 0;
        do_reset();
        l_req_a = 1; l_write_a = 1; l_addr_a = 4'd2; l_data_a = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 15) late15 = l_refresh_late;
            if (k == 16) late16 = l_refresh_late;
            if (l_refresh_late && first < 0) first = k;
            if (first > 0 && !l_refresh_late) drops++;
            if (l_ack_a) acks++;
        end
        l_req_a = 0;
        tests_run++; if (late15 !== 1'b0) begin fails++; $display("FAIL late_before_expiry: got %b expected 0", late15); end
        tests_run++; if (late16 !== 1'b1 || first !== 16) begin fails++; $display("FAIL late_set: got %b first %0d expected 1 first 16", late16, first); end
        tests_run++; if (drops !== 0) begin fails++; $display("FAIL late_sticky: got %0d drops expected 0", drops); end
        tests_run++; if ((acks > 0) !== 1'b1) begin fails++; $display("FAIL late_traffic: got %0d acks expected >0", acks); end
        do_reset();
        vec = {l_ack_a, l_ack_b, l_rd_data, l_cell_addr, l_cell_data_out, l_write_edge, l_read_edge, l_busy, l_refresh_late, l_dbg_state};
        tests_run++; if (vec !== 15'd0) begin fails++; $display("FAIL late_cleared_by_reset: got %h expected 0", vec); end
    endtask

    task automatic test_reset_mid();
        int sc, ac, aw, lost; logic [1:0] kd; logic [3:0] sa; logic sd, rv; bit xa; logic [14:0] vec;
        lost = 0;
        do_reset();
        req_a = 1; write_a = 1; addr_a = 4'd7; data_a = 1;
        repeat (2) @(negedge clk);
        tests_run++; if (write_edge !== 1'b1 || cell_addr !== 4'd7) begin fails++; $display("FAIL mid_strobe_up: got we %b addr %0d expected 1 addr 7", write_edge, cell_addr); end
        #2 n_reset = 1'b0;
        #1;
        tests_run++; if (write_edge !== 1'b0) begin fails++; $display("FAIL mid_strobe_drop: got %b expected 0", write_edge); end
        vec = {ack_a, ack_b, rd_data, cell_addr, cell_data_out, write_edge, read_edge, busy, refresh_late, dbg_state};
        tests_run++; if (vec !== 15'd0) begin fails++; $display("FAIL mid_outputs_zero: got %h expected 0", vec); end
        req_a = 0;
        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack_a || busy) lost++;
        end
        tests_run++; if (lost !== 0) begin fails++; $display("FAIL mid_request_lost: got %0d active cycles expected 0", lost); end
        run_op(0, 1, 4'd7, 1, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (sc !== 2 || ac !== 5) begin fails++; $display("FAIL mid_reissue: got strobe %0d ack %0d expected 2 and 5", sc, ac); end
        run_op(0, 0, 4'd7, 0, sc, ac, aw, kd, sa, sd, rv, xa);
        tests_run++; if (rv !== 1'b1) begin fails++; $display("FAIL mid_readback: got %b expected 1", rv); end
    endtask

    initial begin
        tests_run = 0; fails = 0;
        n_reset = 1'b0; mem_clr = 1'b1;
        req_a = 0; req_b = 0; write_a = 0; write_b = 0; data_a = 0; data_b = 0; addr_a = '0; addr_b = '0;
        l_req_a = 0; l_req_b = 0; l_write_a = 0; l_write_b = 0; l_data_a = 0; l_data_b = 0;
        l_addr_a = '0; l_addr_b = '0; l_cell_data_in = 0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_refresh();
        test_refresh_vs_req();
        test_refresh_late();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
